// File: rtl/fetch_unit_if.sv
// Handshake bundles around the fetch stage: scheduler -> fetch, fetch <-> I-cache, fetch -> decode.
// In each bundle the master modport is the side that drives the valid signal.

interface fetch_sched_if #(
    parameter int NW_W        = 2,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44
);
    logic                   sched_valid;
    logic                   sched_ready;
    logic [NW_W-1:0]        sched_wid;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [XLEN-1:0]        sched_pc;
    logic [UUID_WIDTH-1:0]  sched_uuid;

    modport master (output sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
                    input  sched_ready);
    modport slave  (input  sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
                    output sched_ready);
endinterface

interface fetch_icache_if #(
    parameter int NW_W        = 2,
    parameter int XLEN        = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   icache_req_valid;
    logic                   icache_req_ready;
    logic [XLEN-3:0]        icache_req_addr;
    logic [NW_W-1:0]        icache_req_tag;
    logic                   icache_rsp_valid;
    logic                   icache_rsp_ready;
    logic [NW_W-1:0]        icache_rsp_tag;
    logic [INSTR_WIDTH-1:0] icache_rsp_data;

    modport master (output icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready,
                    input  icache_req_ready, icache_rsp_valid, icache_rsp_tag, icache_rsp_data);
    modport slave  (input  icache_req_valid, icache_req_addr, icache_req_tag, icache_rsp_ready,
                    output icache_req_ready, icache_rsp_valid, icache_rsp_tag, icache_rsp_data);
endinterface

interface fetch_decode_if #(
    parameter int NW_W        = 2,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int INSTR_WIDTH = 32
);
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [NW_W-1:0]        fetch_wid;
    logic [NUM_THREADS-1:0] fetch_tmask;
    logic [XLEN-1:0]        fetch_pc;
    logic [UUID_WIDTH-1:0]  fetch_uuid;
    logic [INSTR_WIDTH-1:0] fetch_instr;

    modport master (output fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
                    input  fetch_ready);
    modport slave  (input  fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
                    output fetch_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one I-cache read per scheduled warp, metadata joined with the returned word.
// Optional FETCH_PERF_EN adds saturating stall/fetch performance counters.

module fetch_unit #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_sched_if.slave         sched,
    fetch_icache_if.master       icache,
    fetch_decode_if.master       fetch,
    output logic [NUM_WARPS-1:0] pending_mask,
    output logic                 err_unexpected_rsp,
    output logic                 busy
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]          perf_stall_cycles,
    output logic [63:0]          perf_fetches
`endif
);
    localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]  uuid;
        logic [NW_W-1:0]        wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [NUM_WARPS-1:0]   pending_r;
    logic                   err_r;
    logic [1:0]             count_r;
    entry_t                 head_r;
    entry_t                 tail_r;
    logic [NUM_THREADS-1:0] meta_tmask_r [NUM_WARPS];
    logic [XLEN-1:0]        meta_pc_r    [NUM_WARPS];
    logic [UUID_WIDTH-1:0]  meta_uuid_r  [NUM_WARPS];

    logic                   blocked_s;
    logic                   req_fire_s;
    logic                   ready_in_s;
    logic                   rsp_fire_s;
    logic                   rsp_hit_s;
    logic                   push_s;
    logic                   pop_s;
    logic [NUM_WARPS-1:0]   set_mask_s;
    logic [NUM_WARPS-1:0]   clr_mask_s;
    entry_t                 new_entry_s;

    // Request/response handshakes and pending-mask update masks
    always_comb begin
        blocked_s  = pending_r[sched.sched_wid];
        req_fire_s = sched.sched_valid & icache.icache_req_ready & ~blocked_s;
        ready_in_s = (count_r != 2'd2);
        rsp_fire_s = icache.icache_rsp_valid & ready_in_s;
        rsp_hit_s  = pending_r[icache.icache_rsp_tag];
        push_s     = rsp_fire_s & rsp_hit_s;
        pop_s      = (count_r != 2'd0) & fetch.fetch_ready;

        sched.sched_ready       = icache.icache_req_ready & ~blocked_s;
        icache.icache_req_valid = sched.sched_valid & ~blocked_s;
        icache.icache_req_addr  = sched.sched_pc[XLEN-1:2];
        icache.icache_req_tag   = sched.sched_wid;
        icache.icache_rsp_ready = ready_in_s;

        for (int w = 0; w < NUM_WARPS; w++) begin
            set_mask_s[w] = req_fire_s && (sched.sched_wid == NW_W'(w));
            clr_mask_s[w] = push_s && (icache.icache_rsp_tag == NW_W'(w));
        end

        new_entry_s.uuid  = meta_uuid_r[icache.icache_rsp_tag];
        new_entry_s.wid   = icache.icache_rsp_tag;
        new_entry_s.tmask = meta_tmask_r[icache.icache_rsp_tag];
        new_entry_s.pc    = meta_pc_r[icache.icache_rsp_tag];
        new_entry_s.instr = icache.icache_rsp_data;
    end

    // Pending bits, sticky error flag and output-buffer occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NUM_WARPS{1'b0}};
            err_r     <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
            if (rsp_fire_s && !rsp_hit_s) begin
                err_r <= 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Output buffer data; head_r always holds the oldest entry so fetch_* is registered
    always_ff @(posedge clk) begin
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) head_r <= new_entry_s;
                else                 tail_r <= new_entry_s;
            end
            2'b01: head_r <= tail_r;
            2'b11: begin
                if (count_r == 2'd1) begin
                    head_r <= new_entry_s;
                end else begin
                    head_r <= tail_r;
                    tail_r <= new_entry_s;
                end
            end
            default: begin
            end
        endcase
    end

    // Per-warp metadata captured at request time; deliberately not reset
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            meta_tmask_r[sched.sched_wid] <= sched.sched_tmask;
            meta_pc_r[sched.sched_wid]    <= sched.sched_pc;
            meta_uuid_r[sched.sched_wid]  <= sched.sched_uuid;
        end
    end

    assign fetch.fetch_valid = (count_r != 2'd0);
    assign fetch.fetch_wid   = head_r.wid;
    assign fetch.fetch_tmask = head_r.tmask;
    assign fetch.fetch_pc    = head_r.pc;
    assign fetch.fetch_uuid  = head_r.uuid;
    assign fetch.fetch_instr = head_r.instr;

    assign pending_mask       = pending_r;
    assign err_unexpected_rsp = err_r;
    assign busy               = (|pending_r) | (count_r != 2'd0);

`ifdef FETCH_PERF_EN
    logic [63:0] perf_stall_r;
    logic [63:0] perf_fetch_r;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_r <= 64'd0;
            perf_fetch_r <= 64'd0;
        end else begin
            if (sched.sched_valid && !sched.sched_ready && !(&perf_stall_r)) begin
                perf_stall_r <= perf_stall_r + 64'd1;
            end
            if (pop_s && !(&perf_fetch_r)) begin
                perf_fetch_r <= perf_fetch_r + 64'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_fetches      = perf_fetch_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a queue-based model.

module tb_fetch_unit;
    localparam int NUM_WARPS   = 4;
    localparam int NW_W        = 2;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int UUID_WIDTH  = 44;
    localparam int INSTR_WIDTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NUM_WARPS-1:0] pending_mask;
    logic err_unexpected_rsp;
    logic busy;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_stall_cycles;
    logic [63:0] perf_fetches;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_sched_if  #(.NW_W(NW_W), .NUM_THREADS(NUM_THREADS), .XLEN(XLEN), .UUID_WIDTH(UUID_WIDTH)) sb();
    fetch_icache_if #(.NW_W(NW_W), .XLEN(XLEN), .INSTR_WIDTH(INSTR_WIDTH)) ib();
    fetch_decode_if #(.NW_W(NW_W), .NUM_THREADS(NUM_THREADS), .XLEN(XLEN), .UUID_WIDTH(UUID_WIDTH),
                      .INSTR_WIDTH(INSTR_WIDTH)) db();

    fetch_unit #(.NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS), .XLEN(XLEN),
                 .UUID_WIDTH(UUID_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .sched              (sb),
        .icache             (ib),
        .fetch              (db),
        .pending_mask       (pending_mask),
        .err_unexpected_rsp (err_unexpected_rsp),
        .busy               (busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_fetches       (perf_fetches)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb.sched_valid = 1'b0; sb.sched_wid = '0; sb.sched_tmask = '0; sb.sched_pc = '0; sb.sched_uuid = '0;
        ib.icache_req_ready = 1'b1; ib.icache_rsp_valid = 1'b0; ib.icache_rsp_tag = '0; ib.icache_rsp_data = '0;
        db.fetch_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [1:0] w, input logic [31:0] pc, input logic [3:0] tm, input logic [43:0] uu);
        sb.sched_valid = 1'b1; sb.sched_wid = w; sb.sched_pc = pc; sb.sched_tmask = tm; sb.sched_uuid = uu;
        ib.icache_req_ready = 1'b1;
        tick();
        sb.sched_valid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] tag, input logic [31:0] data);
        ib.icache_rsp_valid = 1'b1; ib.icache_rsp_tag = tag; ib.icache_rsp_data = data;
        tick();
        ib.icache_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (pending_mask !== 4'b0000) $display("FAIL reset_pending: got %b exp 0000", pending_mask); else pass_cnt++;
        total_cnt++; if (db.fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid: got %b exp 0", db.fetch_valid); else pass_cnt++;
        total_cnt++; if (err_unexpected_rsp !== 1'b0) $display("FAIL reset_err: got %b exp 0", err_unexpected_rsp); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        sb.sched_valid = 1'b1; sb.sched_wid = 2'd1; sb.sched_pc = 32'h8000_0004;
        sb.sched_tmask = 4'b0011; sb.sched_uuid = 44'h123_4567_89AB;
        #1;
        total_cnt++; if (ib.icache_req_valid !== 1'b1) $display("FAIL single_req_valid: got %b exp 1", ib.icache_req_valid); else pass_cnt++;
        total_cnt++; if (ib.icache_req_addr !== 30'h2000_0001) $display("FAIL single_req_addr: got %h exp 20000001", ib.icache_req_addr); else pass_cnt++;
        total_cnt++; if (ib.icache_req_tag !== 2'd1) $display("FAIL single_req_tag: got %0d exp 1", ib.icache_req_tag); else pass_cnt++;
        total_cnt++; if (sb.sched_ready !== 1'b1) $display("FAIL single_sched_ready: got %b exp 1", sb.sched_ready); else pass_cnt++;
        tick();
        sb.sched_valid = 1'b0;
        total_cnt++; if (pending_mask !== 4'b0010) $display("FAIL single_pending_set: got %b exp 0010", pending_mask); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b exp 1", busy); else pass_cnt++;
        ib.icache_rsp_valid = 1'b1; ib.icache_rsp_tag = 2'd1; ib.icache_rsp_data = 32'h0000_0513;
        db.fetch_ready = 1'b1;
        #1;
        total_cnt++; if (ib.icache_rsp_ready !== 1'b1) $display("FAIL single_rsp_ready: got %b exp 1", ib.icache_rsp_ready); else pass_cnt++;
        total_cnt++; if (db.fetch_valid !== 1'b0) $display("FAIL single_no_early_valid: got %b exp 0", db.fetch_valid); else pass_cnt++;
        tick();
        ib.icache_rsp_valid = 1'b0;
        total_cnt++; if (db.fetch_valid !== 1'b1) $display("FAIL single_fetch_valid: got %b exp 1", db.fetch_valid); else pass_cnt++;
        total_cnt++; if ({db.fetch_wid, db.fetch_tmask, db.fetch_pc} !== {2'd1, 4'b0011, 32'h8000_0004})
            $display("FAIL single_meta: got wid=%0d tm=%b pc=%h exp wid=1 tm=0011 pc=80000004", db.fetch_wid, db.fetch_tmask, db.fetch_pc); else pass_cnt++;
        total_cnt++; if (db.fetch_instr !== 32'h0000_0513) $display("FAIL single_instr: got %h exp 00000513", db.fetch_instr); else pass_cnt++;
        total_cnt++; if (db.fetch_uuid !== 44'h123_4567_89AB) $display("FAIL single_uuid: got %h exp 123456789ab", db.fetch_uuid); else pass_cnt++;
        total_cnt++; if (pending_mask !== 4'b0000) $display("FAIL single_pending_clr: got %b exp 0000", pending_mask); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_per_warp_block();
        db.fetch_ready = 1'b1;
        issue(2'd2, 32'h300, 4'b0100, 44'h7);
        sb.sched_valid = 1'b1; sb.sched_wid = 2'd2; sb.sched_pc = 32'h304; sb.sched_tmask = 4'b1100; sb.sched_uuid = 44'h8;
        #1;
        total_cnt++; if ({sb.sched_ready, ib.icache_req_valid} !== 2'b00) $display("FAIL block_pending: got rdy/req=%b exp 00", {sb.sched_ready, ib.icache_req_valid}); else pass_cnt++;
        tick();
        ib.icache_rsp_valid = 1'b1; ib.icache_rsp_tag = 2'd2; ib.icache_rsp_data = 32'hCAFE_0001;
        #1;
        total_cnt++; if ({sb.sched_ready, ib.icache_req_valid} !== 2'b00) $display("FAIL block_same_cycle: got rdy/req=%b exp 00", {sb.sched_ready, ib.icache_req_valid}); else pass_cnt++;
        tick();
        ib.icache_rsp_valid = 1'b0;
        #1;
        total_cnt++; if ({sb.sched_ready, ib.icache_req_valid} !== 2'b11) $display("FAIL block_next_cycle: got rdy/req=%b exp 11", {sb.sched_ready, ib.icache_req_valid}); else pass_cnt++;
        total_cnt++; if (db.fetch_pc !== 32'h300) $display("FAIL block_out_pc: got %h exp 300", db.fetch_pc); else pass_cnt++;
        tick();
        sb.sched_valid = 1'b0;
        total_cnt++; if (pending_mask !== 4'b0100) $display("FAIL block_reissue: got %b exp 0100", pending_mask); else pass_cnt++;
        respond(2'd2, 32'hCAFE_0002);
        total_cnt++; if (db.fetch_pc !== 32'h304) $display("FAIL block_reissue_pc: got %h exp 304", db.fetch_pc); else pass_cnt++;
        tick();
    endtask

    task automatic test_out_of_order();
        db.fetch_ready = 1'b1;
        issue(2'd0, 32'h100, 4'b0001, 44'hA_AAAA);
        issue(2'd3, 32'h200, 4'b1000, 44'hB_BBBB);
        total_cnt++; if (pending_mask !== 4'b1001) $display("FAIL ooo_pending: got %b exp 1001", pending_mask); else pass_cnt++;
        respond(2'd3, 32'h0000_3333);
        total_cnt++; if ({db.fetch_valid, db.fetch_wid, db.fetch_pc, db.fetch_tmask, db.fetch_uuid, db.fetch_instr} !==
                         {1'b1, 2'd3, 32'h200, 4'b1000, 44'hB_BBBB, 32'h0000_3333})
            $display("FAIL ooo_first: got v=%b wid=%0d pc=%h tm=%b uuid=%h exp v=1 wid=3 pc=200 tm=1000 uuid=bbbbb", db.fetch_valid, db.fetch_wid, db.fetch_pc, db.fetch_tmask, db.fetch_uuid); else pass_cnt++;
        respond(2'd0, 32'h0000_0000);
        total_cnt++; if ({db.fetch_valid, db.fetch_wid, db.fetch_pc, db.fetch_tmask, db.fetch_uuid} !==
                         {1'b1, 2'd0, 32'h100, 4'b0001, 44'hA_AAAA})
            $display("FAIL ooo_second: got v=%b wid=%0d pc=%h tm=%b uuid=%h exp v=1 wid=0 pc=100 tm=0001 uuid=aaaaa", db.fetch_valid, db.fetch_wid, db.fetch_pc, db.fetch_tmask, db.fetch_uuid); else pass_cnt++;
        tick();
        total_cnt++; if (db.fetch_valid !== 1'b0) $display("FAIL ooo_drained: got %b exp 0", db.fetch_valid); else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        logic [1:0] got[$];
        logic       rsp_acc;
        int         got_w;
        db.fetch_ready = 1'b0;
        issue(2'd0, 32'h400, 4'b0001, 44'h40);
        issue(2'd1, 32'h404, 4'b0010, 44'h41);
        issue(2'd2, 32'h408, 4'b0100, 44'h42);
        for (int k = 0; k < 3; k++) begin
            ib.icache_rsp_valid = 1'b1; ib.icache_rsp_tag = 2'(k); ib.icache_rsp_data = 32'h900 + 32'(k);
            #1;
            total_cnt++; if (ib.icache_rsp_ready !== (k < 2)) $display("FAIL bp_rsp_ready_%0d: got %b exp %b", k, ib.icache_rsp_ready, (k < 2)); else pass_cnt++;
            tick();
        end
        total_cnt++; if ({db.fetch_valid, db.fetch_wid, db.fetch_pc} !== {1'b1, 2'd0, 32'h400})
            $display("FAIL bp_hold: got v=%b wid=%0d pc=%h exp v=1 wid=0 pc=400", db.fetch_valid, db.fetch_wid, db.fetch_pc); else pass_cnt++;
        total_cnt++; if (pending_mask !== 4'b0100) $display("FAIL bp_pending: got %b exp 0100", pending_mask); else pass_cnt++;
        db.fetch_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            rsp_acc = ib.icache_rsp_valid & ib.icache_rsp_ready;
            if (db.fetch_valid) got.push_back(db.fetch_wid);
            tick();
            if (rsp_acc) ib.icache_rsp_valid = 1'b0;
        end
        total_cnt++; if (got.size() != 3) $display("FAIL bp_count: got %0d exp 3", got.size()); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            got_w = (k < got.size()) ? int'(got[k]) : -1;
            total_cnt++; if (got_w != k) $display("FAIL bp_order_%0d: got wid %0d exp %0d", k, got_w, k); else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL bp_idle: got busy=%b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_unexpected();
        do_reset();
        db.fetch_ready = 1'b1;
        respond(2'd2, 32'hDEAD_BEEF);
        total_cnt++; if (db.fetch_valid !== 1'b0) $display("FAIL unexp_no_output: got %b exp 0", db.fetch_valid); else pass_cnt++;
        total_cnt++; if (err_unexpected_rsp !== 1'b1) $display("FAIL unexp_err: got %b exp 1", err_unexpected_rsp); else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++; if (err_unexpected_rsp !== 1'b1) $display("FAIL unexp_sticky: got %b exp 1", err_unexpected_rsp); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        db.fetch_ready = 1'b1;
        issue(2'd0, 32'h500, 4'b1111, 44'h50);
        issue(2'd1, 32'h504, 4'b1111, 44'h51);
        total_cnt++; if (pending_mask !== 4'b0011) $display("FAIL mid_pending: got %b exp 0011", pending_mask); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if ({pending_mask, db.fetch_valid, busy, err_unexpected_rsp} !== 7'b0000_000)
            $display("FAIL mid_reset: got pend=%b v=%b busy=%b err=%b exp all 0", pending_mask, db.fetch_valid, busy, err_unexpected_rsp); else pass_cnt++;
        respond(2'd0, 32'h1234_5678);
        total_cnt++; if ({db.fetch_valid, err_unexpected_rsp} !== 2'b01) $display("FAIL mid_stale: got v/err=%b exp 01", {db.fetch_valid, err_unexpected_rsp}); else pass_cnt++;
    endtask

    typedef struct {
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [43:0] uuid;
        logic [31:0] instr;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [3:0]  mpend;
        logic [3:0]  mtm[4];
        logic [31:0] mpc[4];
        logic [43:0] muu[4];
        logic [1:0]  plist[$];
        logic        sv, crdy, rv, fr, req_acc, push, pop;
        logic [1:0]  w, tag;
        logic [31:0] pc, data;
        logic [3:0]  tm;
        logic [43:0] uu;
        longint      stalls, pops;
        do_reset();
        mpend = 4'b0000; stalls = 0; pops = 0;
        for (int i = 0; i < 600; i++) begin
            sv = ($urandom_range(0, 3) != 0); w = 2'($urandom_range(0, 3)); pc = $urandom; tm = 4'($urandom);
            uu = {12'($urandom), 32'($urandom)}; crdy = ($urandom_range(0, 3) != 0);
            plist.delete();
            for (int k = 0; k < 4; k++) if (mpend[k]) plist.push_back(2'(k));
            rv = (plist.size() > 0) && ($urandom_range(0, 2) != 0);
            tag = (plist.size() > 0) ? plist[$urandom_range(0, plist.size() - 1)] : 2'd0;
            data = $urandom;
            fr = (i < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            sb.sched_valid = sv; sb.sched_wid = w; sb.sched_pc = pc; sb.sched_tmask = tm; sb.sched_uuid = uu;
            ib.icache_req_ready = crdy; ib.icache_rsp_valid = rv; ib.icache_rsp_tag = tag; ib.icache_rsp_data = data;
            db.fetch_ready = fr;
            #1;
            total_cnt++; if (ib.icache_req_valid !== (sv && !mpend[w])) $display("FAIL rnd_req_valid @%0d: got %b exp %b", i, ib.icache_req_valid, (sv && !mpend[w])); else pass_cnt++;
            total_cnt++; if (sb.sched_ready !== (crdy && !mpend[w])) $display("FAIL rnd_sched_ready @%0d: got %b exp %b", i, sb.sched_ready, (crdy && !mpend[w])); else pass_cnt++;
            if (sv && !mpend[w]) begin
                total_cnt++; if ({ib.icache_req_addr, ib.icache_req_tag} !== {pc[31:2], w}) $display("FAIL rnd_req_addr @%0d: got %h/%0d exp %h/%0d", i, ib.icache_req_addr, ib.icache_req_tag, pc[31:2], w); else pass_cnt++;
            end
            total_cnt++; if (ib.icache_rsp_ready !== (q.size() < 2)) $display("FAIL rnd_rsp_ready @%0d: got %b exp %b", i, ib.icache_rsp_ready, (q.size() < 2)); else pass_cnt++;
            total_cnt++; if (db.fetch_valid !== (q.size() > 0)) $display("FAIL rnd_fetch_valid @%0d: got %b exp %b", i, db.fetch_valid, (q.size() > 0)); else pass_cnt++;
            if (q.size() > 0) begin
                total_cnt++; if ({db.fetch_uuid, db.fetch_wid, db.fetch_tmask, db.fetch_pc, db.fetch_instr} !== {q[0].uuid, q[0].wid, q[0].tmask, q[0].pc, q[0].instr})
                    $display("FAIL rnd_data @%0d: got wid=%0d pc=%h instr=%h exp wid=%0d pc=%h instr=%h", i, db.fetch_wid, db.fetch_pc, db.fetch_instr, q[0].wid, q[0].pc, q[0].instr); else pass_cnt++;
            end
            total_cnt++; if (pending_mask !== mpend) $display("FAIL rnd_pending @%0d: got %b exp %b", i, pending_mask, mpend); else pass_cnt++;
            total_cnt++; if (busy !== ((mpend != 4'b0) || (q.size() > 0))) $display("FAIL rnd_busy @%0d: got %b", i, busy); else pass_cnt++;
            req_acc = sv && crdy && !mpend[w];
            push = rv && (q.size() < 2);
            pop = (q.size() > 0) && fr;
            if (sv && !(crdy && !mpend[w])) stalls++;
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (push) begin
                e.wid = tag; e.tmask = mtm[tag]; e.pc = mpc[tag]; e.uuid = muu[tag]; e.instr = data;
                q.push_back(e);
                mpend[tag] = 1'b0;
            end
            if (req_acc) begin
                mpend[w] = 1'b1; mtm[w] = tm; mpc[w] = pc; muu[w] = uu;
            end
            tick();
        end
        idle_inputs();
        total_cnt++; if (err_unexpected_rsp !== 1'b0) $display("FAIL rnd_no_err: got %b exp 0", err_unexpected_rsp); else pass_cnt++;
`ifdef FETCH_PERF_EN
        total_cnt++; if (perf_stall_cycles !== 64'(stalls)) $display("FAIL perf_stalls: got %0d exp %0d", perf_stall_cycles, stalls); else pass_cnt++;
        total_cnt++; if (perf_fetches !== 64'(pops)) $display("FAIL perf_fetches: got %0d exp %0d", perf_fetches, pops); else pass_cnt++;
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_per_warp_block();
        test_out_of_order();
        test_back_pressure();
        test_unexpected();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly downstream of the warp scheduler, upstream of decode.
- Accepts scheduled warps (wid, tmask, PC, uuid) and issues one I-cache read per warp.
- Holds per-warp metadata while the request is in flight, and joins it with the returned instruction word.
- Emits {uuid, wid, tmask, PC, instr} to decode through a 2-entry elastic output buffer.

Parameters:
NUM_WARPS, 4, warps per core; wid width NW_W = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, thread mask width
XLEN, 32, PC width
UUID_WIDTH, 44, instruction uuid width
INSTR_WIDTH, 32, instruction word width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sched_valid  in  1  scheduled warp valid
sched_ready  out  1  fetch accepts scheduled warp
sched_wid  in  NW_W  warp id
sched_tmask  in  NUM_THREADS  thread mask
sched_pc  in  XLEN  byte PC
sched_uuid  in  UUID_WIDTH  instruction uuid
icache_req_valid  out  1  I-cache read request valid
icache_req_ready  in  1  I-cache accepts request
icache_req_addr  out  XLEN-2  word address = sched_pc[XLEN-1:2]
icache_req_tag  out  NW_W  request tag = sched_wid
icache_rsp_valid  in  1  I-cache response valid
icache_rsp_ready  out  1  fetch accepts response
icache_rsp_tag  in  NW_W  response tag
icache_rsp_data  in  INSTR_WIDTH  instruction word
fetch_valid  out  1  output to decode valid
fetch_ready  in  1  decode accepts output
fetch_wid  out  NW_W  warp id
fetch_tmask  out  NUM_THREADS  thread mask
fetch_pc  out  XLEN  byte PC
fetch_uuid  out  UUID_WIDTH  uuid
fetch_instr  out  INSTR_WIDTH  instruction word
pending_mask  out  NUM_WARPS  per-warp outstanding-request bit
err_unexpected_rsp  out  1  sticky: response arrived for a tag with no pending request
busy  out  1  pending_mask != 0 or output buffer non-empty

Behaviour:
- Request path is combinational in the same cycle:
  - icache_req_valid = sched_valid & ~pending_mask[sched_wid].
  - sched_ready = icache_req_ready & ~pending_mask[sched_wid].
  - Accept (req fire) = sched_valid & sched_ready. No request is issued without an accepted sched transaction.
- On req fire:
  - Write {tmask, pc, uuid} into the per-warp metadata table at index sched_wid.
  - Set pending_mask[sched_wid] on the next clock edge.
- Pending check uses the registered pending_mask only.
  - A response clearing warp w and a new request for warp w in the same cycle: the request is blocked. It can be accepted the following cycle.
  - Requests for other warps in that cycle proceed normally.
- Response path: icache_rsp_ready = output buffer ready_in. On rsp fire:
  - If pending_mask[tag]=1: push {meta[tag], tag, rsp_data} into the output buffer and clear pending_mask[tag].
  - If pending_mask[tag]=0: drop the data, push nothing, and set err_unexpected_rsp.
- Simultaneous set (request, warp a) and clear (response, warp b != a) in one cycle: both take effect.
- Output buffer:
  - 2-entry elastic buffer; full throughput, one transfer per cycle when fetch_ready stays high.
  - Latency: rsp fire in cycle N gives fetch_valid in cycle N+1.
  - fetch_* data is held stable while fetch_valid & ~fetch_ready.
  - When full (2 entries, fetch_ready low), icache_rsp_ready=0 and responses back-pressure.
- Ordering:
  - Responses may return out of order across warps; output order equals response order.
  - At most one request per warp is in flight, so outstanding requests never exceed NUM_WARPS.
- Reset values:
  - pending_mask=0, output buffer empty, fetch_valid=0, err_unexpected_rsp=0, busy=0.
  - Metadata table is not reset.
- Reset mid-operation:
  - All in-flight tags are forgotten. Any late response after reset hits pending=0, is dropped, and sets err_unexpected_rsp.
  - The I-cache is expected to be reset together with this block.
- sched_pc[1:0] is ignored for addressing and is carried unchanged to fetch_pc.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_stall_cycles (64-bit) and perf_fetches (64-bit), both reset to 0, saturating at all-ones.
  - perf_stall_cycles increments each cycle sched_valid & ~sched_ready.
  - perf_fetches increments on each fetch_valid & fetch_ready.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single fetch: sched wid=1, pc=0x80000004, tmask=4'b0011, cache ready. Cycle 0 -> req addr=0x20000001, tag=1; pending_mask=4'b0010. Response tag=1, data=0x00000513 -> next cycle fetch_valid with wid=1, pc=0x80000004, tmask=4'b0011, instr=0x00000513; pending_mask=0.
- Per-warp block: with wid 2 pending, present sched wid=2 -> sched_ready=0, no request. Response for wid 2 and sched wid=2 in the same cycle -> request issued the cycle after.
- Out-of-order: requests wid0 pc=0x100, then wid3 pc=0x200. Responses tag3 then tag0 -> outputs in order wid3/pc 0x200, then wid0/pc 0x100, each with its own tmask/uuid.
- Back-pressure: fetch_ready=0 with 3 back-to-back responses -> 2 buffered, icache_rsp_ready=0 on the third. Raise fetch_ready -> all 3 delivered in response order with no loss or duplication.
- Unexpected response: with pending_mask=0, drive rsp tag=2 -> no fetch_valid, err_unexpected_rsp=1 and stays 1 until reset.
- Reset mid-flight: wids 0 and 1 pending, assert reset for 1 cycle -> pending_mask=0, fetch_valid=0, busy=0. A subsequent stale tag-0 response is dropped and sets the error flag.
